// File: rtl/rf_pkg.sv
// Shared widths and the pending write-back record used by the register-file write side.
// No latency of its own; holds types and constants only.
// No handshake of its own; carries no flow control.
package rf_pkg;

    localparam int REG_ADDR_WIDTH = 5;
    localparam int REG_DATA_WIDTH = 32;
    localparam int NUM_REGS       = 1 << REG_ADDR_WIDTH;

    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0] addr;
        logic [REG_DATA_WIDTH-1:0] data;
        logic                      is_load;
    } wb_req_t;

endpackage

// File: rtl/reg_writeback_unit_if.sv
// Bundle between the pipeline (ALU, LSU, decode) and the register-file write side.
// No latency of its own; wires only.
// Master drives valids and queries; slave returns readies, hazards and the rf write port.
interface reg_writeback_unit_if
    import rf_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic                      alu_wr_valid;
    logic [REG_ADDR_WIDTH-1:0] alu_wr_addr;
    logic [REG_DATA_WIDTH-1:0] alu_wr_data;
    logic                      alu_wr_ready;

    logic                      lsu_wr_valid;
    logic [REG_ADDR_WIDTH-1:0] lsu_wr_addr;
    logic [REG_DATA_WIDTH-1:0] lsu_wr_data;
    logic                      lsu_wr_ready;

    logic                      sb_set_valid;
    logic [REG_ADDR_WIDTH-1:0] sb_set_addr;

    logic [REG_ADDR_WIDTH-1:0] chk_addr1;
    logic [REG_ADDR_WIDTH-1:0] chk_addr2;
    logic                      chk_busy1;
    logic                      chk_busy2;

    logic                      rf_wr_en;
    logic [REG_ADDR_WIDTH-1:0] rf_wr_addr;
    logic [REG_DATA_WIDTH-1:0] rf_wr_data;
    logic [CW-1:0]             pending_count;

    modport master (
        output alu_wr_valid, alu_wr_addr, alu_wr_data,
        input  alu_wr_ready,
        output lsu_wr_valid, lsu_wr_addr, lsu_wr_data,
        input  lsu_wr_ready,
        output sb_set_valid, sb_set_addr,
        output chk_addr1, chk_addr2,
        input  chk_busy1, chk_busy2,
        input  rf_wr_en, rf_wr_addr, rf_wr_data, pending_count
    );

    modport slave (
        input  alu_wr_valid, alu_wr_addr, alu_wr_data,
        output alu_wr_ready,
        input  lsu_wr_valid, lsu_wr_addr, lsu_wr_data,
        output lsu_wr_ready,
        input  sb_set_valid, sb_set_addr,
        input  chk_addr1, chk_addr2,
        output chk_busy1, chk_busy2,
        output rf_wr_en, rf_wr_addr, rf_wr_data, pending_count
    );

endinterface

// File: rtl/wb_fifo.sv
// In-order FIFO of write-back records: two enqueues (port 0 lands first) and one dequeue per cycle.
// Head is visible the cycle after an enqueue into an empty FIFO; head reads zero when empty.
// No internal backpressure: the caller must never enqueue beyond free space.
module wb_fifo
    import rf_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  enq0_vld,
    input  wb_req_t                               enq0_dat,
    input  logic                                  enq1_vld,
    input  wb_req_t                               enq1_dat,
    input  logic                                  deq,
    output wb_req_t                               head_dat,
    output logic [CW-1:0]                         count,
    output logic [DEPTH-1:0]                      ent_vld,
    output logic [DEPTH-1:0][REG_ADDR_WIDTH-1:0]  ent_addr
);

    wb_req_t         mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(enq0_vld) + PW'(enq1_vld);
            rd_ptr <= rd_ptr + PW'(deq);
            count  <= count + CW'(enq0_vld) + CW'(enq1_vld) - CW'(deq);
        end
    end

    // Storage needs no reset: every read is qualified by count/ent_vld.
    always_ff @(posedge clk) begin
        if (enq0_vld)
            mem[wr_ptr] <= enq0_dat;
        if (enq1_vld)
            mem[enq0_vld ? wr_ptr + PW'(1) : wr_ptr] <= enq1_dat;
    end

    assign head_dat = (count != '0) ? mem[rd_ptr] : '0;

    always_comb begin
        ent_vld  = '0;
        ent_addr = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [PW-1:0] off;
            off         = PW'(i) - rd_ptr;
            ent_vld[i]  = {1'b0, off} < count;
            ent_addr[i] = mem[i].addr;
        end
    end

endmodule

// File: rtl/reg_writeback_unit.sv
// Register-file write side: queues ALU/LSU write-backs in order and drains one per cycle; tracks busy loads.
// A request accepted at an edge into an empty queue is written at the next edge.
// Readies come from registered occupancy only; the current cycle's drain is not credited.
module reg_writeback_unit
    import rf_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    reg_writeback_unit_if.slave        bus
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int AW = REG_ADDR_WIDTH;

    logic [CW-1:0]                 count;
    logic [CW-1:0]                 free;
    logic                          lsu_fire;
    logic                          alu_fire;
    logic                          enq0_vld;
    logic                          enq1_vld;
    wb_req_t                       enq0_dat;
    wb_req_t                       enq1_dat;
    wb_req_t                       head;
    logic                          deq;
    logic [FIFO_DEPTH-1:0]         ent_vld;
    logic [FIFO_DEPTH-1:0][AW-1:0] ent_addr;
    logic [NUM_REGS-1:0]           sb;
    logic                          hit1;
    logic                          hit2;

    assign free             = CW'(FIFO_DEPTH) - count;
    assign bus.lsu_wr_ready = free >= CW'(1);
    // A same-cycle LSU transfer takes a slot first, so the ALU then needs two.
    assign bus.alu_wr_ready = (bus.lsu_wr_valid && bus.lsu_wr_ready) ? (free >= CW'(2))
                                                                      : (free >= CW'(1));

    assign lsu_fire = bus.lsu_wr_valid && bus.lsu_wr_ready;
    assign alu_fire = bus.alu_wr_valid && bus.alu_wr_ready;
    assign enq0_vld = lsu_fire && (bus.lsu_wr_addr != '0);
    assign enq1_vld = alu_fire && (bus.alu_wr_addr != '0);
    assign enq0_dat = '{addr: bus.lsu_wr_addr, data: bus.lsu_wr_data, is_load: 1'b1};
    assign enq1_dat = '{addr: bus.alu_wr_addr, data: bus.alu_wr_data, is_load: 1'b0};
    assign deq      = count != '0;

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .enq0_vld (enq0_vld),
        .enq0_dat (enq0_dat),
        .enq1_vld (enq1_vld),
        .enq1_dat (enq1_dat),
        .deq      (deq),
        .head_dat (head),
        .count    (count),
        .ent_vld  (ent_vld),
        .ent_addr (ent_addr)
    );

    assign bus.rf_wr_en      = deq;
    assign bus.rf_wr_addr    = head.addr;
    assign bus.rf_wr_data    = head.data;
    assign bus.pending_count = count;

    // A newly issued load re-marking a register overrides the clear from its previous load draining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (bus.sb_set_valid && (bus.sb_set_addr != '0) && (bus.sb_set_addr == AW'(i)))
                    sb[i] <= 1'b1;
                else if (deq && head.is_load && (head.addr == AW'(i)))
                    sb[i] <= 1'b0;
            end
        end
    end

    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (ent_vld[i] && (ent_addr[i] == bus.chk_addr1))
                hit1 = 1'b1;
            if (ent_vld[i] && (ent_addr[i] == bus.chk_addr2))
                hit2 = 1'b1;
        end
    end

    assign bus.chk_busy1 = (bus.chk_addr1 != '0) && (sb[bus.chk_addr1] || hit1);
    assign bus.chk_busy2 = (bus.chk_addr2 != '0) && (sb[bus.chk_addr2] || hit2);

endmodule
